// File: rtl/prueba_frames_pkg.sv
// Shared encodings, start values and month-length helper for the frame test sequencer.
// Build option: PRUEBA_BISIESTO_EN enables 29-day February in years divisible by 4.
package prueba_frames_pkg;

  localparam logic [2:0] MODO_CERO   = 3'b000;
  localparam logic [2:0] MODO_OCHOS  = 3'b001;
  localparam logic [2:0] MODO_RELOJ  = 3'b010;
  localparam logic [2:0] MODO_FECHA  = 3'b011;
  localparam logic [2:0] MODO_TIMER  = 3'b100;
  localparam logic [2:0] MODO_CURSOR = 3'b101;
  localparam logic [2:0] MODO_TODO   = 3'b110;

  localparam logic [23:0] HMS_INICIO   = 24'h115950;
  localparam logic [23:0] FECHA_INICIO = 24'h270224;
  localparam logic [23:0] TIMER_INICIO = 24'h000105;
  localparam logic [2:0]  DIA_INICIO   = 3'd2;
  localparam logic [23:0] TODO_OCHOS   = 24'h888888;

`ifdef PRUEBA_BISIESTO_EN
  localparam bit BISIESTO_EN = 1'b1;
`else
  localparam bit BISIESTO_EN = 1'b0;
`endif

  // Month and year are BCD; result is the BCD day count of that month.
  function automatic logic [7:0] dias_mes(input logic [7:0] mes, input logic [7:0] anio);
    logic [6:0] anio_bin;
    anio_bin = 7'(anio[7:4]) * 7'd10 + 7'(anio[3:0]);
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: dias_mes = 8'h30;
      8'h02: dias_mes = (BISIESTO_EN && ((anio_bin % 7'd4) == 7'd0)) ? 8'h29 : 8'h28;
      default: dias_mes = 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/contador_bcd_2d.sv
// Two-digit BCD counter, up or down, wrapping between MIN and max_i with carry/borrow out.
module contador_bcd_2d #(
  parameter logic [7:0] MIN = 8'h00,
  parameter bit         UP  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  input  logic [7:0] max_i,
  output logic [7:0] valor_o,
  output logic       carry_o
);

  logic [7:0] valor_q, valor_d;
  logic       limite;

  always_comb begin
    // Up counters use >= so an out-of-range loaded value still wraps cleanly.
    limite  = UP ? (valor_q >= max_i) : (valor_q == MIN);
    valor_d = valor_q;
    if (load_i) begin
      valor_d = load_val_i;
    end else if (en_i) begin
      if (limite) begin
        valor_d = UP ? MIN : max_i;
      end else if (UP) begin
        valor_d = (valor_q[3:0] == 4'd9) ? {valor_q[7:4] + 4'd1, 4'd0}
                                         : {valor_q[7:4], valor_q[3:0] + 4'd1};
      end else begin
        valor_d = (valor_q[3:0] == 4'd0) ? {valor_q[7:4] - 4'd1, 4'd9}
                                         : {valor_q[7:4], valor_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q <= 8'h00;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor_o = valor_q;
  assign carry_o = en_i & ~load_i & limite;

endmodule

// File: rtl/secuenciador_prueba_frames.sv
// Switch-selected static/live stimulus for the VGA clock screen (clock, date, timer, cursor).
// Build option: PRUEBA_BISIESTO_EN (leap-year February, see prueba_frames_pkg).
module secuenciador_prueba_frames
  import prueba_frames_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned NUM_CURSOR = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  sw,
  output logic [23:0] hms_bcd,
  output logic [23:0] fecha_bcd,
  output logic [23:0] timer_bcd,
  output logic        AM_PM,
  output logic [2:0]  dia_semana,
  output logic        funcion,
  output logic [1:0]  cursor_location,
  output logic        tick,
  output logic        timer_done
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned DivW = $clog2(Div);
  localparam logic [DivW-1:0] DivFin = DivW'(Div - 1);
  localparam logic [1:0] CursorFin = 2'(NUM_CURSOR - 1);

  logic [2:0]      sw_meta_q, modo_q, modo_prev_q;
  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic            am_q, am_d, funcion_q, funcion_d, timer_done_q, timer_done_d;
  logic [2:0]      dia_q, dia_d;
  logic [1:0]      cursor_q, cursor_d;
  logic            carga, run;

  logic [23:0] hms_ini, fecha_ini, timer_ini;
  logic        am_ini, funcion_ini;
  logic [2:0]  dia_ini;
  logic [1:0]  cursor_ini;

  logic [7:0] ss, mm, hh, dd, mes, anio, tss, tmm, thh;
  logic       ss_c, mm_c, hh_c, dd_c, mes_c, anio_c, tss_c, tmm_c, thh_c;
  logic       reloj_en, fecha_en, timer_en, cursor_en, vuelta_11, rollover;
  logic       unused_acarreo;

  assign carga = (modo_q != modo_prev_q);
  assign run   = tick_q & ~carga;

  always_comb begin
    hms_ini     = '0;
    fecha_ini   = '0;
    timer_ini   = '0;
    am_ini      = 1'b0;
    dia_ini     = 3'd0;
    funcion_ini = 1'b0;
    cursor_ini  = 2'd0;
    case (modo_q)
      MODO_OCHOS: begin
        hms_ini     = TODO_OCHOS;
        fecha_ini   = TODO_OCHOS;
        timer_ini   = TODO_OCHOS;
        am_ini      = 1'b1;
        dia_ini     = 3'd6;
        funcion_ini = 1'b1;
        cursor_ini  = CursorFin;
      end
      MODO_RELOJ, MODO_FECHA, MODO_TIMER, MODO_TODO: begin
        hms_ini     = HMS_INICIO;
        fecha_ini   = FECHA_INICIO;
        timer_ini   = TIMER_INICIO;
        dia_ini     = DIA_INICIO;
        funcion_ini = (modo_q == MODO_TODO);
      end
      MODO_CURSOR: funcion_ini = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    div_d  = (carga || div_q == DivFin) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DivFin);
  end

  always_comb begin
    reloj_en  = run & (modo_q == MODO_RELOJ || modo_q == MODO_TODO);
    vuelta_11 = mm_c & (hh == 8'h11);
    // 11:59:59 PM -> 12:00:00 AM is the only clock event that advances the date.
    rollover  = vuelta_11 & am_q;
    fecha_en  = (run & (modo_q == MODO_FECHA)) | ((modo_q == MODO_TODO) & rollover);
    timer_en  = run & (modo_q == MODO_TIMER || modo_q == MODO_TODO) & (timer_bcd != 24'h0);
    cursor_en = run & (modo_q == MODO_CURSOR || modo_q == MODO_TODO);
  end

  always_comb begin
    am_d         = am_q;
    dia_d        = dia_q;
    funcion_d    = funcion_q;
    cursor_d     = cursor_q;
    timer_done_d = 1'b0;
    if (carga) begin
      am_d      = am_ini;
      dia_d     = dia_ini;
      funcion_d = funcion_ini;
      cursor_d  = cursor_ini;
    end else begin
      if (vuelta_11) am_d = ~am_q;
      if (fecha_en) dia_d = (dia_q >= 3'd6) ? 3'd0 : dia_q + 3'd1;
      if (cursor_en) cursor_d = (cursor_q >= CursorFin) ? 2'd0 : cursor_q + 2'd1;
      timer_done_d = timer_en & (timer_bcd == 24'h000001);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q    <= 3'b000;
      modo_q       <= 3'b000;
      modo_prev_q  <= 3'b000;
      div_q        <= '0;
      tick_q       <= 1'b0;
      am_q         <= 1'b0;
      dia_q        <= 3'd0;
      funcion_q    <= 1'b0;
      cursor_q     <= 2'd0;
      timer_done_q <= 1'b0;
    end else begin
      sw_meta_q    <= sw;
      modo_q       <= sw_meta_q;
      modo_prev_q  <= modo_q;
      div_q        <= div_d;
      tick_q       <= tick_d;
      am_q         <= am_d;
      dia_q        <= dia_d;
      funcion_q    <= funcion_d;
      cursor_q     <= cursor_d;
      timer_done_q <= timer_done_d;
    end
  end

  contador_bcd_2d #(.MIN(8'h00), .UP(1'b1)) u_ss (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(hms_ini[7:0]),
    .en_i(reloj_en), .max_i(8'h59), .valor_o(ss), .carry_o(ss_c)
  );
  contador_bcd_2d #(.MIN(8'h00), .UP(1'b1)) u_mm (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(hms_ini[15:8]),
    .en_i(ss_c), .max_i(8'h59), .valor_o(mm), .carry_o(mm_c)
  );
  contador_bcd_2d #(.MIN(8'h01), .UP(1'b1)) u_hh (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(hms_ini[23:16]),
    .en_i(mm_c), .max_i(8'h12), .valor_o(hh), .carry_o(hh_c)
  );

  contador_bcd_2d #(.MIN(8'h01), .UP(1'b1)) u_dd (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(fecha_ini[23:16]),
    .en_i(fecha_en), .max_i(dias_mes(mes, anio)), .valor_o(dd), .carry_o(dd_c)
  );
  contador_bcd_2d #(.MIN(8'h01), .UP(1'b1)) u_mes (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(fecha_ini[15:8]),
    .en_i(dd_c), .max_i(8'h12), .valor_o(mes), .carry_o(mes_c)
  );
  contador_bcd_2d #(.MIN(8'h00), .UP(1'b1)) u_anio (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(fecha_ini[7:0]),
    .en_i(mes_c), .max_i(8'h99), .valor_o(anio), .carry_o(anio_c)
  );

  contador_bcd_2d #(.MIN(8'h00), .UP(1'b0)) u_tss (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(timer_ini[7:0]),
    .en_i(timer_en), .max_i(8'h59), .valor_o(tss), .carry_o(tss_c)
  );
  contador_bcd_2d #(.MIN(8'h00), .UP(1'b0)) u_tmm (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(timer_ini[15:8]),
    .en_i(tss_c), .max_i(8'h59), .valor_o(tmm), .carry_o(tmm_c)
  );
  contador_bcd_2d #(.MIN(8'h00), .UP(1'b0)) u_thh (
    .clock(clock), .reset(reset), .load_i(carga), .load_val_i(timer_ini[23:16]),
    .en_i(tmm_c), .max_i(8'h99), .valor_o(thh), .carry_o(thh_c)
  );

  assign unused_acarreo = ^{hh_c, anio_c, thh_c};

  assign hms_bcd         = {hh, mm, ss};
  assign fecha_bcd       = {dd, mes, anio};
  assign timer_bcd       = {thh, tmm, tss};
  assign AM_PM           = am_q;
  assign dia_semana      = dia_q;
  assign funcion         = funcion_q;
  assign cursor_location = cursor_q;
  assign tick            = tick_q;
  assign timer_done      = timer_done_q;

endmodule

// File: tb/tb_secuenciador_prueba_frames.sv
// Self-checking bench: randomized timing against a seconds/day-count reference model.
module tb_secuenciador_prueba_frames;

  localparam int unsigned CLK_HZ     = 10;
  localparam int unsigned TICK_HZ    = 1;
  localparam int unsigned NUM_CURSOR = 3;
`ifdef PRUEBA_BISIESTO_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic        clock, reset;
  logic [2:0]  sw;
  logic [23:0] hms_bcd, fecha_bcd, timer_bcd;
  logic        AM_PM, funcion, tick, timer_done;
  logic [2:0]  dia_semana;
  logic [1:0]  cursor_location;
  logic [80:0] todas;

  int checks = 0;
  int failures = 0;
  int done_pulsos = 0;
  int secs, dd, mes, anio, wd, trem, cur;

  secuenciador_prueba_frames #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CURSOR(NUM_CURSOR)
  ) dut (
    .clock(clock), .reset(reset), .sw(sw),
    .hms_bcd(hms_bcd), .fecha_bcd(fecha_bcd), .timer_bcd(timer_bcd),
    .AM_PM(AM_PM), .dia_semana(dia_semana), .funcion(funcion),
    .cursor_location(cursor_location), .tick(tick), .timer_done(timer_done)
  );

  assign todas = {hms_bcd, fecha_bcd, timer_bcd, AM_PM, dia_semana, funcion,
                  cursor_location, tick, timer_done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (timer_done === 1'b1) done_pulsos++;

  function automatic logic [7:0] bcd2(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic logic [23:0] hms_exp(input int s);
    int h24, h12;
    h24 = s / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    return {bcd2(h12), bcd2((s / 60) % 60), bcd2(s % 60)};
  endfunction

  function automatic logic [23:0] timer_exp(input int r);
    return {bcd2(r / 3600), bcd2((r / 60) % 60), bcd2(r % 60)};
  endfunction

  function automatic int largo_mes(input int m, input int y);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
    return 31;
  endfunction

  task automatic modelo_dia();
    dd++;
    wd = (wd + 1) % 7;
    if (dd > largo_mes(mes, anio)) begin
      dd = 1;
      mes++;
      if (mes > 12) begin
        mes = 1;
        anio = (anio + 1) % 100;
      end
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic set_modo(input logic [2:0] m);
    repeat ($urandom_range(0, 6)) ciclo();
    sw = m;
    repeat (3) ciclo();
  endtask

  // Returns one cycle after a tick, when the advanced values are visible.
  task automatic avanzar_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      ciclo();
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: no tick within %0d cycles, want one within 10", n);
    end
    ciclo();
  endtask

  task automatic test_reset();
    sw = 3'b000;
    #2 reset = 1'b0;
    repeat (3) ciclo();
    checks++;
    if (todas !== '0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", todas);
    end
    reset = 1'b1;
    ciclo();
    checks++;
    if (todas !== '0) begin
      failures++;
      $display("FAIL reset_release: got %h want 0", todas);
    end
  endtask

  task automatic test_ochos();
    sw = 3'b001;
    ciclo();
    ciclo();
    checks++;
    if (hms_bcd !== 24'h000000) begin
      failures++;
      $display("FAIL ochos_early: got %h want 000000", hms_bcd);
    end
    ciclo();
    checks++;
    if ({hms_bcd, fecha_bcd, timer_bcd} !== {3{24'h888888}}) begin
      failures++;
      $display("FAIL ochos_digits: got %h %h %h want 888888", hms_bcd, fecha_bcd, timer_bcd);
    end
    checks++;
    if ({AM_PM, dia_semana, funcion, cursor_location} !== {1'b1, 3'd6, 1'b1, 2'(NUM_CURSOR - 1)})
    begin
      failures++;
      $display("FAIL ochos_flags: got am=%b dia=%0d fn=%b cur=%0d want 1 6 1 %0d",
               AM_PM, dia_semana, funcion, cursor_location, NUM_CURSOR - 1);
    end
  endtask

  task automatic test_reloj();
    set_modo(3'b010);
    secs = 11 * 3600 + 59 * 60 + 50;
    checks++;
    if (hms_bcd !== 24'h115950 || AM_PM !== 1'b0) begin
      failures++;
      $display("FAIL reloj_start: got %h am=%b want 115950 am=0", hms_bcd, AM_PM);
    end
    for (int i = 0; i < 10 + 3599 + 1; i++) begin
      avanzar_tick();
      secs = (secs + 1) % 86400;
      checks++;
      if (hms_bcd !== hms_exp(secs) || AM_PM !== (secs >= 43200)) begin
        failures++;
        $display("FAIL reloj_tick%0d: got %h am=%b want %h am=%b", i, hms_bcd, AM_PM,
                 hms_exp(secs), secs >= 43200);
      end
      if (i == 9) begin
        checks++;
        if (hms_bcd !== 24'h120000 || AM_PM !== 1'b1) begin
          failures++;
          $display("FAIL reloj_noon: got %h am=%b want 120000 am=1", hms_bcd, AM_PM);
        end
      end
    end
    checks++;
    if (hms_bcd !== 24'h010000 || AM_PM !== 1'b1) begin
      failures++;
      $display("FAIL reloj_12to01: got %h am=%b want 010000 am=1", hms_bcd, AM_PM);
    end
  endtask

  task automatic test_fecha();
    int n;
    set_modo(3'b011);
    dd = 27; mes = 2; anio = 24; wd = 2;
    checks++;
    if (fecha_bcd !== 24'h270224 || dia_semana !== 3'd2) begin
      failures++;
      $display("FAIL fecha_start: got %h dia=%0d want 270224 dia=2", fecha_bcd, dia_semana);
    end
    n = 3 + int'($urandom_range(20, 400));
    for (int i = 0; i < n; i++) begin
      avanzar_tick();
      modelo_dia();
      checks++;
      if (fecha_bcd !== {bcd2(dd), bcd2(mes), bcd2(anio)} || dia_semana !== 3'(wd)) begin
        failures++;
        $display("FAIL fecha_tick%0d: got %h dia=%0d want %h dia=%0d", i, fecha_bcd,
                 dia_semana, {bcd2(dd), bcd2(mes), bcd2(anio)}, wd);
      end
      if (i == 2) begin
        checks++;
        if (fecha_bcd !== (LEAP ? 24'h010324 : 24'h020324) || dia_semana !== 3'd5) begin
          failures++;
          $display("FAIL fecha_feb: got %h dia=%0d want %h dia=5", fecha_bcd, dia_semana,
                   LEAP ? 24'h010324 : 24'h020324);
        end
      end
    end
  endtask

  task automatic test_timer();
    int base;
    logic exp_done;
    set_modo(3'b100);
    trem = 65;
    base = done_pulsos;
    checks++;
    if (timer_bcd !== 24'h000105 || timer_done !== 1'b0) begin
      failures++;
      $display("FAIL timer_start: got %h done=%b want 000105 done=0", timer_bcd, timer_done);
    end
    for (int i = 0; i < 70; i++) begin
      avanzar_tick();
      exp_done = 1'b0;
      if (trem > 0) begin
        trem--;
        exp_done = (trem == 0);
      end
      checks++;
      if (timer_bcd !== timer_exp(trem) || timer_done !== exp_done) begin
        failures++;
        $display("FAIL timer_tick%0d: got %h done=%b want %h done=%b", i, timer_bcd,
                 timer_done, timer_exp(trem), exp_done);
      end
    end
    checks++;
    if (done_pulsos - base != 1) begin
      failures++;
      $display("FAIL timer_pulses: got %0d want 1", done_pulsos - base);
    end
  endtask

  task automatic test_cursor();
    int n;
    set_modo(3'b101);
    cur = 0;
    checks++;
    if (cursor_location !== 2'd0 || funcion !== 1'b1 || hms_bcd !== 24'h0 || AM_PM !== 1'b0)
    begin
      failures++;
      $display("FAIL cursor_start: got cur=%0d fn=%b hms=%h am=%b want 0 1 000000 0",
               cursor_location, funcion, hms_bcd, AM_PM);
    end
    n = int'($urandom_range(4, 10));
    for (int i = 0; i < n; i++) begin
      avanzar_tick();
      cur = (cur + 1) % NUM_CURSOR;
      checks++;
      if (cursor_location !== 2'(cur) || funcion !== 1'b1) begin
        failures++;
        $display("FAIL cursor_tick%0d: got cur=%0d fn=%b want %0d fn=1", i,
                 cursor_location, funcion, cur);
      end
    end
  endtask

  task automatic test_todo();
    int n;
    set_modo(3'b110);
    secs = 11 * 3600 + 59 * 60 + 50;
    dd = 27; mes = 2; anio = 24; wd = 2;
    trem = 65;
    cur = 0;
    checks++;
    if ({hms_bcd, fecha_bcd, timer_bcd, funcion, cursor_location}
        !== {24'h115950, 24'h270224, 24'h000105, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL todo_start: got %h %h %h fn=%b cur=%0d", hms_bcd, fecha_bcd, timer_bcd,
               funcion, cursor_location);
    end
    n = int'($urandom_range(15, 40));
    for (int i = 0; i < n; i++) begin
      avanzar_tick();
      secs = (secs + 1) % 86400;
      if (secs == 0) modelo_dia();
      if (trem > 0) trem--;
      cur = (cur + 1) % NUM_CURSOR;
      checks++;
      if (hms_bcd !== hms_exp(secs) || AM_PM !== (secs >= 43200) ||
          fecha_bcd !== {bcd2(dd), bcd2(mes), bcd2(anio)} || timer_bcd !== timer_exp(trem) ||
          cursor_location !== 2'(cur)) begin
        failures++;
        $display("FAIL todo_tick%0d: got %h/%b %h %h %0d want %h/%b %h %h %0d", i, hms_bcd,
                 AM_PM, fecha_bcd, timer_bcd, cursor_location, hms_exp(secs), secs >= 43200,
                 {bcd2(dd), bcd2(mes), bcd2(anio)}, timer_exp(trem), cur);
      end
    end
  endtask

  // The sw change is timed so the load cycle lands on a tick cycle.
  task automatic test_colision();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      ciclo();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL colision_sync: no tick found, want one within 10 cycles");
    end
    repeat (8) ciclo();
    sw = 3'b011;
    ciclo();
    ciclo();
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL colision_tick: got tick=%b in load cycle want 1", tick);
    end
    ciclo();
    checks++;
    if (fecha_bcd !== 24'h270224 || dia_semana !== 3'd2) begin
      failures++;
      $display("FAIL colision_load: got %h dia=%0d want 270224 dia=2", fecha_bcd, dia_semana);
    end
    n = 1;
    while (tick !== 1'b1 && n < 15) begin
      ciclo();
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL colision_next_tick: got %0d cycles want 10", n);
    end
    ciclo();
    checks++;
    if (fecha_bcd !== 24'h280224 || dia_semana !== 3'd3) begin
      failures++;
      $display("FAIL colision_after: got %h dia=%0d want 280224 dia=3", fecha_bcd, dia_semana);
    end
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(3, 25)) ciclo();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (todas !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", todas);
    end
    ciclo();
    reset = 1'b1;
    ciclo();
    ciclo();
    checks++;
    if (todas !== '0) begin
      failures++;
      $display("FAIL reset_after: got %h want 0", todas);
    end
    ciclo();
    checks++;
    if (fecha_bcd !== 24'h270224 || dia_semana !== 3'd2) begin
      failures++;
      $display("FAIL reset_reload: got %h dia=%0d want 270224 dia=2", fecha_bcd, dia_semana);
    end
  endtask

  initial begin
    reset = 1'b1;
    sw = 3'b000;
    test_reset();
    test_ochos();
    test_reloj();
    test_fecha();
    test_timer();
    test_cursor();
    test_todo();
    test_colision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
